// File: rtl/c_ram_port_arbiter_if.sv
// Bundles both requester ports and the RAM port of the C RAM arbiter.
// Latency: none, wires only.
// Backpressure: requesters wait for their gnt; the RAM side has no backpressure.
interface c_ram_port_arbiter_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
);
  // operand read requester
  logic              rd_req;
  logic              rd_last;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_gnt;
  logic [DATA_W-1:0] rd_rdata;
  logic              rd_rvalid;
  // result store requester
  logic              wr_req;
  logic              wr_last;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_wdata;
  logic              wr_gnt;
  // single-port RAM
  logic              ram_en;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;
  // status
  logic              burst_err;

  // arbiter side
  modport slave (
    input  rd_req, rd_last, rd_addr,
    output rd_gnt, rd_rdata, rd_rvalid,
    input  wr_req, wr_last, wr_addr, wr_wdata,
    output wr_gnt,
    output ram_en, ram_we, ram_addr, ram_wdata,
    input  ram_rdata,
    output burst_err
  );

  // requester / RAM model side
  modport master (
    output rd_req, rd_last, rd_addr,
    input  rd_gnt, rd_rdata, rd_rvalid,
    output wr_req, wr_last, wr_addr, wr_wdata,
    input  wr_gnt,
    input  ram_en, ram_we, ram_addr, ram_wdata,
    output ram_rdata,
    input  burst_err
  );
endinterface

// File: rtl/c_ram_port_arbiter.sv
// Round-robin, burst-granular arbiter sharing the single-port C RAM between the operand reader and result writer.
// Latency: req->gnt 1 cycle; RAM signals combinational from the owner's beat; rd_rvalid 1 cycle after a read beat.
// Backpressure: non-owner waits on gnt; owner may stall by dropping req (grant held); bursts cut at MAX_BURST beats.
module c_ram_port_arbiter #(
  parameter int ADDR_W    = 10,
  parameter int DATA_W    = 32,
  parameter int MAX_BURST = 33
) (
  input  logic                 clk,
  input  logic                 rst,
  c_ram_port_arbiter_if.slave  bus
);

  localparam int CNT_W = $clog2(MAX_BURST + 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RD_BURST = 2'd1,
    WR_BURST = 2'd2
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic [CNT_W-1:0]   beat_cnt;
  logic [CNT_W-1:0]   beat_cnt_nxt;
  logic               prio_wr;        // 1: writer wins a tie in IDLE
  logic               prio_wr_nxt;
  logic               burst_err_q;
  logic               burst_err_nxt;
  logic               rvalid_q;

  logic               beat_acc;       // owner presents a beat this cycle
  logic               own_last;
  logic               at_max;         // current beat would be beat MAX_BURST
  logic [ADDR_W-1:0]  addr_mux;
  logic [DATA_W-1:0]  wdata_mux;

  // State, beat count, round-robin pointer and truncation flag registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      beat_cnt    <= '0;
      prio_wr     <= 1'b1;
      burst_err_q <= 1'b0;
    end else begin
      state       <= state_nxt;
      beat_cnt    <= beat_cnt_nxt;
      prio_wr     <= prio_wr_nxt;
      burst_err_q <= burst_err_nxt;
    end
  end

  // Next-state: grant selection in IDLE, beat counting and burst termination
  always_comb begin
    state_nxt     = state;
    beat_cnt_nxt  = beat_cnt;
    prio_wr_nxt   = prio_wr;
    burst_err_nxt = 1'b0;
    beat_acc      = 1'b0;
    own_last      = 1'b0;
    at_max        = (beat_cnt == CNT_W'(MAX_BURST - 1));

    case (state)
      IDLE: begin
        beat_cnt_nxt = '0;
        if (bus.rd_req && (!bus.wr_req || !prio_wr)) begin
          state_nxt   = RD_BURST;
          prio_wr_nxt = 1'b1;
        end else if (bus.wr_req) begin
          state_nxt   = WR_BURST;
          prio_wr_nxt = 1'b0;
        end
      end
      RD_BURST: begin
        beat_acc = bus.rd_req;
        own_last = bus.rd_last;
      end
      WR_BURST: begin
        beat_acc = bus.wr_req;
        own_last = bus.wr_last;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase

    // A beat numbered MAX_BURST ends the burst even without last; that
    // case is flagged so the requester knows its burst was cut short.
    if (beat_acc) begin
      if (own_last || at_max) begin
        state_nxt     = IDLE;
        beat_cnt_nxt  = '0;
        burst_err_nxt = !own_last;
      end else begin
        beat_cnt_nxt  = beat_cnt + CNT_W'(1);
      end
    end
  end

  // Address/data mux onto the RAM from whichever requester owns the port
  always_comb begin
    addr_mux  = '0;
    wdata_mux = '0;
    case (state)
      RD_BURST: addr_mux = bus.rd_addr;
      WR_BURST: begin
        addr_mux  = bus.wr_addr;
        wdata_mux = bus.wr_wdata;
      end
      default: begin
        addr_mux  = '0;
        wdata_mux = '0;
      end
    endcase
  end

  // Read-valid tracks the RAM's one-cycle read latency; reset drops it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rvalid_q <= 1'b0;
    end else begin
      rvalid_q <= beat_acc && (state == RD_BURST);
    end
  end

  assign bus.rd_gnt    = (state == RD_BURST);
  assign bus.wr_gnt    = (state == WR_BURST);
  assign bus.ram_en    = beat_acc;
  assign bus.ram_we    = (state == WR_BURST);
  assign bus.ram_addr  = addr_mux;
  assign bus.ram_wdata = wdata_mux;
  assign bus.rd_rdata  = bus.ram_rdata;
  assign bus.rd_rvalid = rvalid_q;
  assign bus.burst_err = burst_err_q;

endmodule

// File: tb/tb_c_ram_port_arbiter.sv
// Directed bench for c_ram_port_arbiter with a behavioural single-port RAM.
// Inputs change 1 ns after the rising edge, outputs are checked 1 ns later.
// Every check goes through chk(); the summary prints the check/error counts.
module tb_c_ram_port_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  c_ram_port_arbiter_if #(.ADDR_W(10), .DATA_W(32)) bus ();

  c_ram_port_arbiter #(.ADDR_W(10), .DATA_W(32), .MAX_BURST(33)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // behavioural RAM: 1-cycle read latency, plus a preload port for the bench
  logic [31:0] mem [0:1023];
  logic        pl_en   = 1'b0;
  logic [9:0]  pl_addr = '0;
  logic [31:0] pl_dat  = '0;

  always @(posedge clk) begin
    if (pl_en) mem[pl_addr] <= pl_dat;
    else if (bus.ram_en && bus.ram_we) mem[bus.ram_addr] <= bus.ram_wdata;
    if (bus.ram_en && !bus.ram_we) bus.ram_rdata <= mem[bus.ram_addr];
  end

  int both_cnt = 0;
  always @(negedge clk) begin
    if (bus.rd_gnt && bus.wr_gnt) both_cnt <= both_cnt + 1;
  end

  int n_checks = 0;
  int n_errors = 0;
  int n_wr;
  logic ew, er;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    bus.rd_req = 0; bus.rd_last = 0; bus.rd_addr = '0;
    bus.wr_req = 0; bus.wr_last = 0; bus.wr_addr = '0; bus.wr_wdata = '0;
    #2;
    // ---- reset state
    chk("rst_rd_gnt", bus.rd_gnt, 0);
    chk("rst_wr_gnt", bus.wr_gnt, 0);
    chk("rst_rvalid", bus.rd_rvalid, 0);
    chk("rst_burst_err", bus.burst_err, 0);
    chk("rst_ram_en", bus.ram_en, 0);
    chk("rst_ram_we", bus.ram_we, 0);
    chk("rst_ram_addr", bus.ram_addr, 0);
    chk("rst_ram_wdata", bus.ram_wdata, 0);

    // preload read data while still in reset
    for (int i = 0; i < 4; i++) begin
      pl_en = 1; pl_addr = 10'(16 + i); pl_dat = 32'hA0 + i;
      step();
    end
    pl_en = 0;
    rst = 0;
    step();

    // ---- write burst: 33 beats to 0x040..0x060, data = addr
    bus.wr_req = 1; bus.wr_addr = 10'h040; bus.wr_wdata = 32'h40; bus.wr_last = 0;
    #1 chk("wr_gnt_latency", bus.wr_gnt, 0);
    step();
    for (int i = 0; i < 33; i++) begin
      bus.wr_addr = 10'(32'h40 + i); bus.wr_wdata = 32'h40 + i; bus.wr_last = (i == 32);
      #1;
      chk("wb_gnt", bus.wr_gnt, 1);
      chk("wb_en", bus.ram_en, 1);
      chk("wb_we", bus.ram_we, 1);
      chk("wb_addr", bus.ram_addr, 32'h40 + i);
      chk("wb_wdata", bus.ram_wdata, 32'h40 + i);
      chk("wb_err", bus.burst_err, 0);
      step();
    end
    bus.wr_req = 0; bus.wr_last = 0;
    #1;
    chk("wb_end_gnt", bus.wr_gnt, 0);
    chk("wb_end_en", bus.ram_en, 0);
    chk("wb_end_err", bus.burst_err, 0);
    step();
    for (int i = 0; i < 33; i++) chk("wb_mem", mem[32'h40 + i], 32'h40 + i);

    // ---- read burst: 4 beats from 0x010
    bus.rd_req = 1; bus.rd_addr = 10'h010; bus.rd_last = 0;
    #1 chk("rd_gnt_latency", bus.rd_gnt, 0);
    step();
    for (int i = 0; i < 4; i++) begin
      bus.rd_addr = 10'(16 + i); bus.rd_last = (i == 3);
      #1;
      chk("rb_gnt", bus.rd_gnt, 1);
      chk("rb_en", bus.ram_en, 1);
      chk("rb_we", bus.ram_we, 0);
      chk("rb_addr", bus.ram_addr, 16 + i);
      chk("rb_rvalid", bus.rd_rvalid, (i != 0));
      if (i > 0) chk("rb_rdata", bus.rd_rdata, 32'hA0 + i - 1);
      step();
    end
    bus.rd_req = 0; bus.rd_last = 0;
    #1;
    chk("rb_end_gnt", bus.rd_gnt, 0);
    chk("rb_end_en", bus.ram_en, 0);
    chk("rb_end_rvalid", bus.rd_rvalid, 1);
    chk("rb_end_rdata", bus.rd_rdata, 32'hA3);
    step();
    chk("rb_rvalid_off", bus.rd_rvalid, 0);

    // ---- stall: read owner drops req for 3 cycles while writer waits
    bus.rd_req = 1; bus.rd_addr = 10'h010; bus.rd_last = 0;
    step();
    bus.wr_req = 1; bus.wr_addr = 10'h300; bus.wr_wdata = 32'h55; bus.wr_last = 1;
    #1;
    chk("st_b1_gnt", bus.rd_gnt, 1);
    chk("st_b1_en", bus.ram_en, 1);
    chk("st_b1_addr", bus.ram_addr, 32'h10);
    step();
    for (int k = 0; k < 3; k++) begin
      bus.rd_req = 0;
      #1;
      chk("st_gap_rd_gnt", bus.rd_gnt, 1);
      chk("st_gap_wr_gnt", bus.wr_gnt, 0);
      chk("st_gap_en", bus.ram_en, 0);
      if (k == 0) begin
        chk("st_rvalid1", bus.rd_rvalid, 1);
        chk("st_rdata1", bus.rd_rdata, 32'hA0);
      end
      step();
    end
    bus.rd_req = 1; bus.rd_addr = 10'h011; bus.rd_last = 1;
    #1;
    chk("st_b2_gnt", bus.rd_gnt, 1);
    chk("st_b2_wr_gnt", bus.wr_gnt, 0);
    chk("st_b2_en", bus.ram_en, 1);
    chk("st_b2_addr", bus.ram_addr, 32'h11);
    step();
    bus.rd_req = 0; bus.rd_last = 0;
    #1;
    chk("st_idle_rd_gnt", bus.rd_gnt, 0);
    chk("st_idle_wr_gnt", bus.wr_gnt, 0);
    chk("st_rvalid2", bus.rd_rvalid, 1);
    chk("st_rdata2", bus.rd_rdata, 32'hA1);
    step();
    #1;
    chk("st_wr_gnt", bus.wr_gnt, 1);
    chk("st_wr_en", bus.ram_en, 1);
    chk("st_wr_we", bus.ram_we, 1);
    chk("st_wr_addr", bus.ram_addr, 32'h300);
    step();
    bus.wr_req = 0; bus.wr_last = 0;
    #1 chk("st_wr_done", bus.wr_gnt, 0);
    step();
    chk("st_mem", mem[10'h300], 32'h55);

    // ---- contention after reset: 2-beat bursts from both, WR first
    rst = 1;
    step();
    rst = 0;
    for (int t = 0; t < 13; t++) begin
      ew = (t % 6 == 1) || (t % 6 == 2);
      er = (t % 6 == 4) || (t % 6 == 5);
      bus.wr_req = (t < 12); bus.rd_req = (t < 12);
      bus.wr_last = (t % 6 == 2); bus.rd_last = (t % 6 == 5);
      bus.wr_addr = 10'(32'h100 + t); bus.wr_wdata = 32'h100 + t;
      bus.rd_addr = 10'(32'h200 + t);
      #1;
      chk("ct_wr_gnt", bus.wr_gnt, ew);
      chk("ct_rd_gnt", bus.rd_gnt, er);
      chk("ct_en", bus.ram_en, ew | er);
      chk("ct_we", bus.ram_we, ew);
      step();
    end
    bus.wr_last = 0; bus.rd_last = 0;

    // ---- truncation: writer never sets last
    bus.wr_req = 1; bus.wr_addr = 10'h080; bus.wr_wdata = 32'h1000;
    #1 chk("tr_gnt_latency", bus.wr_gnt, 0);
    step();
    n_wr = 0;
    for (int i = 0; i < 33; i++) begin
      bus.wr_addr = 10'(32'h80 + i); bus.wr_wdata = 32'h1000 + i;
      #1;
      if (bus.ram_en && bus.ram_we) n_wr++;
      chk("tr_gnt", bus.wr_gnt, 1);
      chk("tr_err_low", bus.burst_err, 0);
      step();
    end
    #1;
    chk("tr_idle_gnt", bus.wr_gnt, 0);
    chk("tr_idle_en", bus.ram_en, 0);
    chk("tr_err_pulse", bus.burst_err, 1);
    chk("tr_write_count", n_wr, 33);
    step();
    for (int j = 0; j < 7; j++) begin
      bus.wr_addr = 10'(32'hC0 + j);
      #1;
      chk("tr_regnt", bus.wr_gnt, 1);
      chk("tr_regnt_en", bus.ram_en, 1);
      chk("tr_err_once", bus.burst_err, 0);
      step();
    end
    bus.wr_req = 0;
    #1;
    chk("tr_hold_gnt", bus.wr_gnt, 1);
    chk("tr_hold_en", bus.ram_en, 0);
    step();
    bus.wr_req = 1; bus.wr_last = 1;
    #1 chk("tr_close_en", bus.ram_en, 1);
    step();
    bus.wr_req = 0; bus.wr_last = 0;
    #1;
    chk("tr_close_gnt", bus.wr_gnt, 0);
    chk("tr_close_err", bus.burst_err, 0);
    step();

    // ---- reset during the 5th write beat
    bus.wr_req = 1; bus.wr_addr = 10'h020; bus.wr_last = 0;
    step();
    for (int i = 0; i < 4; i++) begin
      bus.wr_addr = 10'(32'h20 + i);
      #1 chk("rm_beat_en", bus.ram_en, 1);
      step();
    end
    bus.wr_addr = 10'h024; bus.wr_wdata = 32'hDEAD;
    #1 chk("rm_b5_en", bus.ram_en, 1);
    rst = 1;
    #1;
    chk("rm_wr_gnt", bus.wr_gnt, 0);
    chk("rm_rd_gnt", bus.rd_gnt, 0);
    chk("rm_en", bus.ram_en, 0);
    chk("rm_we", bus.ram_we, 0);
    chk("rm_addr", bus.ram_addr, 0);
    chk("rm_wdata", bus.ram_wdata, 0);
    chk("rm_err", bus.burst_err, 0);
    chk("rm_rvalid", bus.rd_rvalid, 0);
    step();
    #1 chk("rm_held_gnt", bus.wr_gnt, 0);
    rst = 0;
    step();
    for (int i = 0; i < 33; i++) begin
      bus.wr_addr = 10'(32'h20 + i); bus.wr_last = (i == 32);
      #1;
      chk("rm_gnt", bus.wr_gnt, 1);
      chk("rm_beat", bus.ram_en, 1);
      chk("rm_no_err", bus.burst_err, 0);
      step();
    end
    bus.wr_req = 0; bus.wr_last = 0;
    #1;
    chk("rm_end_gnt", bus.wr_gnt, 0);
    chk("rm_end_err", bus.burst_err, 0);
    step();

    chk("gnt_exclusive", both_cnt, 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
